// File: rtl/shade_motor_sequencer_if.sv
// Target handshake and motor/status bundle between the level decoder, the sequencer and the home controller.
// The obstruct sensor line exists only when SHADE_OBSTRUCT_EN is defined.
interface shade_motor_sequencer_if;
  logic [3:0] target;
  logic       target_valid;
  logic       target_ready;
  logic [3:0] position;
  logic       motor_up;
  logic       motor_down;
  logic       busy;
  logic       done;
  logic       fault;
`ifdef SHADE_OBSTRUCT_EN
  logic       obstruct;

  modport master (
    output target, target_valid, obstruct,
    input  target_ready, position, motor_up, motor_down, busy, done, fault
  );

  modport slave (
    input  target, target_valid, obstruct,
    output target_ready, position, motor_up, motor_down, busy, done, fault
  );
`else
  modport master (
    output target, target_valid,
    input  target_ready, position, motor_up, motor_down, busy, done, fault
  );

  modport slave (
    input  target, target_valid,
    output target_ready, position, motor_up, motor_down, busy, done, fault
  );
`endif
endinterface

// File: rtl/shade_motor_sequencer.sv
// Steps the shade motor one level per STEP_CYCLES toward a latched target, then settles and pulses done.
// Defining SHADE_OBSTRUCT_EN adds the obstruction abort into the FAULT state.
module shade_motor_sequencer #(
  parameter int STEP_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  shade_motor_sequencer_if.slave        bus
);

  localparam int CMAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(32'd1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    pos_r, pos_s;
  logic [3:0]    tgt_r, tgt_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          done_r, done_s;
  logic          fault_r, fault_s;
  logic          busy_r, busy_s;
  logic          ready_r;
  logic          motor_up_r, motor_down_r;
  logic          accept_s;

  // Next-state, step counter and position update
  always_comb begin
    state_s  = state_r;
    pos_s    = pos_r;
    tgt_s    = tgt_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
    fault_s  = fault_r;
    accept_s = bus.target_valid && ready_r;
    case (state_r)
      ST_IDLE, ST_FAULT: begin
        if (accept_s) begin
          tgt_s   = bus.target;
          fault_s = 1'b0;
          cnt_s   = CNT_ZERO;
          if (bus.target > pos_r) begin
            state_s = ST_MOVE_UP;
          end else if (bus.target < pos_r) begin
            state_s = ST_MOVE_DOWN;
          end else begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_MOVE_UP: begin
`ifdef SHADE_OBSTRUCT_EN
        // An obstruction aborts before the pending step lands, so position keeps the last full step
        if (bus.obstruct) begin
          state_s = ST_FAULT;
          fault_s = 1'b1;
          cnt_s   = CNT_ZERO;
        end else
`endif
        if (cnt_r == STEP_LAST) begin
          pos_s = pos_r + 4'd1;
          cnt_s = CNT_ZERO;
          if (pos_s == tgt_r) begin
            state_s = ST_SETTLE;
          end else begin
            state_s = ST_MOVE_UP;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_MOVE_DOWN: begin
        if (cnt_r == STEP_LAST) begin
          pos_s = pos_r - 4'd1;
          cnt_s = CNT_ZERO;
          if (pos_s == tgt_r) begin
            state_s = ST_SETTLE;
          end else begin
            state_s = ST_MOVE_DOWN;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
    busy_s = (state_s == ST_MOVE_UP) || (state_s == ST_MOVE_DOWN) || (state_s == ST_SETTLE);
  end

  // State register and registered output decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pos_r        <= 4'd0;
      tgt_r        <= 4'd0;
      cnt_r        <= CNT_ZERO;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b1;
      motor_up_r   <= 1'b0;
      motor_down_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pos_r        <= pos_s;
      tgt_r        <= tgt_s;
      cnt_r        <= cnt_s;
      done_r       <= done_s;
      fault_r      <= fault_s;
      busy_r       <= busy_s;
      ready_r      <= !busy_s;
      motor_up_r   <= (state_s == ST_MOVE_UP);
      motor_down_r <= (state_s == ST_MOVE_DOWN);
    end
  end

  assign bus.position     = pos_r;
  assign bus.motor_up     = motor_up_r;
  assign bus.motor_down   = motor_down_r;
  assign bus.busy         = busy_r;
  assign bus.target_ready = ready_r;
  assign bus.done         = done_r;
  assign bus.fault        = fault_r;

endmodule

// File: tb/tb_shade_motor_sequencer.sv
// Directed scoreboard bench for shade_motor_sequencer: expected done cycle/position queued at acceptance,
// checked when done pulses; define SHADE_OBSTRUCT_EN to also exercise the obstruction abort.
module tb_shade_motor_sequencer;

  localparam int STEP   = 8;
  localparam int SETTLE = 4;

  typedef struct {
    int         cyc;
    logic [3:0] pos;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_run;
  int   n_fail;
  exp_t q[$];
  logic [3:0] model_pos;
  logic [3:0] prev_pos;

  shade_motor_sequencer_if bus ();

  shade_motor_sequencer #(
    .STEP_CYCLES   (STEP),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on done plus per-cycle motor/position invariants
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_pos = 4'd0;
    end else begin
      check("motor_exclusive", {31'd0, bus.motor_up & bus.motor_down}, 32'd0);
      if (bus.position != prev_pos) begin
        check("position_step_no_wrap",
              {31'd0, ((bus.position == prev_pos + 4'd1) && (prev_pos != 4'd15)) ||
                      ((bus.position == prev_pos - 4'd1) && (prev_pos != 4'd0))}, 32'd1);
      end
      prev_pos = bus.position;
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_position", {28'd0, bus.position}, {28'd0, e.pos});
          check("done_ready", {31'd0, bus.target_ready}, 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [3:0] t, output int e_cyc);
    int n;
    int d;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.target       = t;
    bus.target_valid = 1'b1;
    while (!bus.target_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, bus.target_ready}, 32'd1);
    @(posedge clk);
    #1;
    e_cyc = cyc;
    bus.target_valid = 1'b0;
    d = (t > model_pos) ? int'(t) - int'(model_pos) : int'(model_pos) - int'(t);
    e.cyc = (d == 0) ? e_cyc : e_cyc + d * STEP + SETTLE;
    e.pos = t;
    q.push_back(e);
    check("accept_motor_up", {31'd0, bus.motor_up}, {31'd0, t > model_pos});
    check("accept_motor_down", {31'd0, bus.motor_down}, {31'd0, t < model_pos});
    check("accept_busy", {31'd0, bus.busy}, {31'd0, d != 0});
    model_pos = t;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int e;
    int e2;
    int n;
    exp_t x;
    cyc = 0;
    n_run = 0;
    n_fail = 0;
    model_pos = 4'd0;
    prev_pos = 4'd0;
    rst = 1'b1;
    bus.target = 4'd0;
    bus.target_valid = 1'b0;
`ifdef SHADE_OBSTRUCT_EN
    bus.obstruct = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_position", {28'd0, bus.position}, 32'd0);
    check("rst_motor_up", {31'd0, bus.motor_up}, 32'd0);
    check("rst_motor_down", {31'd0, bus.motor_down}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_ready", {31'd0, bus.target_ready}, 32'd1);

    // Full close 0 -> 15
    send(4'd15, e);
    repeat (60) @(posedge clk);
    #1;
    check("mid_close_position", {28'd0, bus.position}, 32'd7);
    check("mid_close_motor_up", {31'd0, bus.motor_up}, 32'd1);
    wait_done(300);

    // Partial open 15 -> 12
    send(4'd12, e);
    wait_done(100);

    // Equal target: immediate done, no motion
    send(4'd12, e);
    check("equal_done_next_cycle", {31'd0, bus.done}, 32'd1);
    wait_done(10);

    // New target held during a move is taken on the edge closing the done cycle
    send(4'd5, e);
    bus.target = 4'd9;
    bus.target_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 200) begin
      check("held_not_ready", {31'd0, bus.target_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    check("held_done_seen", {31'd0, bus.done}, 32'd1);
    @(posedge clk);
    #1;
    e2 = cyc;
    bus.target_valid = 1'b0;
    check("held_accept_edge", e2, e + 7 * STEP + SETTLE + 1);
    check("held_motor_up", {31'd0, bus.motor_up}, 32'd1);
    x.cyc = e2 + 4 * STEP + SETTLE;
    x.pos = 4'd9;
    q.push_back(x);
    model_pos = 4'd9;
    wait_done(100);

    // Reset in the middle of a full close
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_pos = 4'd0;
    send(4'd15, e);
    repeat (59) @(posedge clk);
    @(negedge clk);
    check("pre_rst_position", {28'd0, bus.position}, 32'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_motor_up", {31'd0, bus.motor_up}, 32'd0);
    check("mid_rst_position", {28'd0, bus.position}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.target_ready}, 32'd1);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    q.delete();
    model_pos = 4'd0;
    @(negedge clk);
    rst = 1'b0;

`ifdef SHADE_OBSTRUCT_EN
    // Obstruction during closing aborts into FAULT; reopening clears it
    send(4'd15, e);
    repeat (19) @(posedge clk);
    @(negedge clk);
    bus.obstruct = 1'b1;
    @(posedge clk);
    #1;
    bus.obstruct = 1'b0;
    check("obst_fault", {31'd0, bus.fault}, 32'd1);
    check("obst_motor_up", {31'd0, bus.motor_up}, 32'd0);
    check("obst_position", {28'd0, bus.position}, 32'd2);
    check("obst_busy", {31'd0, bus.busy}, 32'd0);
    check("obst_ready", {31'd0, bus.target_ready}, 32'd1);
    q.delete();
    model_pos = 4'd2;
    repeat (40) @(negedge clk);
    check("obst_hold_position", {28'd0, bus.position}, 32'd2);
    send(4'd0, e);
    check("obst_fault_cleared", {31'd0, bus.fault}, 32'd0);
    wait_done(100);
    check("obst_final_position", {28'd0, bus.position}, 32'd0);
`else
    send(4'd3, e);
    wait_done(100);
    check("no_obst_fault", {31'd0, bus.fault}, 32'd0);
`endif

    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
